// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx arbitration blocks.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, HOLD, SEND} arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester bus, uart_tx handshake and grant status between the arbiter and its environment.
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ*BYTE_W-1:0]   req_data;
  logic [NREQ-1:0]          req_last;
  logic [NREQ-1:0]          req_ready;
  logic                     tx_start;
  logic [BYTE_W-1:0]        tx_data;
  logic                     tx_busy;
  logic                     tx_done;
  logic [NREQ-1:0]          grant;
  logic [$clog2(NREQ)-1:0]  grant_id;
  logic                     active;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_start, tx_data, grant, grant_id, active
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data, grant, grant_id, active
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NREQ);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ byte-stream requesters: round-robin per packet,
// one byte in flight, grant forcibly released after MAX_BURST bytes.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic              active_q, active_d;
  logic              tx_start_q, tx_start_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              last_flag_q, last_flag_d;

  logic [IDX_W-1:0]  start_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              accept;

  // Search starts just past the previous owner, so it ranks lowest next round.
  assign start_ptr = (grant_id_q == IDX_W'(NREQ - 1)) ? '0 : grant_id_q + IDX_W'(1);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (start_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign accept        = (state_q == HOLD) && bus.req_valid[grant_id_q] && !bus.tx_busy;
  assign bus.req_ready = (state_q == HOLD) ? (grant_q & {NREQ{~bus.tx_busy}}) : '0;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    active_d    = active_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    burst_cnt_d = burst_cnt_q;
    last_flag_d = last_flag_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = NREQ'(1) << pick_idx;
          grant_id_d  = pick_idx;
          active_d    = 1'b1;
          burst_cnt_d = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          tx_data_d   = bus.req_data[int'(grant_id_q)*BYTE_W +: BYTE_W];
          tx_start_d  = 1'b1;
          last_flag_d = bus.req_last[grant_id_q];
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          state_d     = SEND;
        end
      end
      SEND: begin
        if (bus.tx_done) begin
          if (last_flag_q || burst_cnt_q == CNT_W'(MAX_BURST)) begin
            grant_d  = '0;
            active_d = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d  = HOLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_id_q  <= IDX_W'(NREQ - 1);
      active_q    <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      burst_cnt_q <= '0;
      last_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      active_q    <= active_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      burst_cnt_q <= burst_cnt_d;
      last_flag_q <= last_flag_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a small uart_tx model,
// and a monitor that checks every tx_start against the expected byte order.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;
  localparam int FRAME     = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0]      rq [NREQ][$];
  logic [9:0]      exp_q [$];
  logic            force_busy = 1'b0;
  logic            spur_done  = 1'b0;
  logic            m_busy = 1'b0;
  logic            m_done = 1'b0;
  int              m_cnt  = 0;
  logic [NREQ-1:0] acc    = '0;
  int              starts = 0;
  int              rel_cnt = 0;
  int              ready_bad = 0;
  int              data_glitch = 0;
  logic            prev_active = 1'b0;
  logic [7:0]      prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input int id, input logic [7:0] data, input logic last);
    rq[id].push_back({last, data});
  endtask

  task automatic expect_byte(input int id, input logic [7:0] data);
    exp_q.push_back({2'(id), data});
  endtask

  function automatic bit queues_empty();
    if (exp_q.size() != 0) return 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (n < budget && !(bus.active == 1'b0 && queues_empty())) begin
      wait_cyc(1);
      n++;
    end
    check({name, "_finished"}, 32'(n < budget), 32'd1);
  endtask

  // Environment: uart_tx model and requester drivers update on the falling edge,
  // the monitor samples just after, well away from the rising edge.
  initial begin : env
    logic [NREQ-1:0]        v;
    logic [NREQ-1:0]        l;
    logic [NREQ*8-1:0]      d;
    logic [8:0]             h;
    logic [9:0]             e;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_busy   = 1'b0;
    bus.tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_cnt  = 0;
      end else begin
        m_done = 1'b0;
        if (m_busy) begin
          if (m_cnt <= 1) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_cnt--;
          end
        end
        if (bus.tx_start) begin
          m_busy = 1'b1;
          m_cnt  = FRAME;
        end
        for (int i = 0; i < NREQ; i++)
          if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      end
      bus.tx_busy = m_busy | force_busy;
      bus.tx_done = m_done | spur_done;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < NREQ; i++) begin
        h = 9'h000;
        if (rq[i].size() != 0) begin
          h    = rq[i][0];
          v[i] = 1'b1;
        end
        l[i]        = h[8];
        d[8*i +: 8] = h[7:0];
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;

      #1;
      if (!rst) begin
        if (bus.tx_start) begin
          starts++;
          check("start_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_owner_byte", 32'({bus.grant_id, bus.tx_data}), 32'(e));
          end
        end
        if ((bus.req_ready & ~bus.grant) != '0 ||
            (bus.req_ready != '0 && (bus.tx_start || !bus.active)))
          ready_bad++;
        if (!bus.tx_start && bus.tx_data != prev_data) data_glitch++;
        if (prev_active && !bus.active) rel_cnt++;
      end
      prev_active = bus.active;
      prev_data   = bus.tx_data;
      acc         = rst ? '0 : (bus.req_valid & bus.req_ready);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int s0;

    // Reset asserted before any clock edge: outputs must settle asynchronously.
    #2 rst = 1'b1;
    #1;
    check("rst_grant",    32'(bus.grant),     32'h0);
    check("rst_grant_id", 32'(bus.grant_id),  32'd3);
    check("rst_active",   32'(bus.active),    32'd0);
    check("rst_tx_start", 32'(bus.tx_start),  32'd0);
    check("rst_tx_data",  32'(bus.tx_data),   32'h00);
    check("rst_ready",    32'(bus.req_ready), 32'h0);
    wait_cyc(2);
    rst = 1'b0;

    // 1: single byte from req0
    push_byte(0, 8'hA5, 1'b1);
    expect_byte(0, 8'hA5);
    wait_cyc(1);
    check("t1_grant",  32'(bus.grant),  32'b0001);
    check("t1_active", 32'(bus.active), 32'd1);
    wait_cyc(1);
    check("t1_tx_start", 32'(bus.tx_start), 32'd1);
    check("t1_tx_data",  32'(bus.tx_data),  32'hA5);
    wait_done("t1", 50);
    check("t1_grant_rel",  32'(bus.grant),    32'h0);
    check("t1_grant_id",   32'(bus.grant_id), 32'd0);

    // 2: req1 and req3 compete; req1 is next after pointer 0
    for (int b = 0; b < 3; b++) begin
      push_byte(1, 8'h10 + 8'(b), b == 2);
      push_byte(3, 8'h30 + 8'(b), b == 2);
    end
    for (int b = 0; b < 3; b++) expect_byte(1, 8'h10 + 8'(b));
    for (int b = 0; b < 3; b++) expect_byte(3, 8'h30 + 8'(b));
    wait_cyc(1);
    check("t2_first_grant", 32'(bus.grant), 32'b0010);
    wait_done("t2", 200);
    check("t2_ready_owner_only", 32'(ready_bad), 32'd0);
    check("t2_grant_id", 32'(bus.grant_id), 32'd3);

    // 3: req2 streams 40 bytes; req0 squeezes its packet in after the first burst
    rel_cnt = 0;
    for (int b = 0; b < 40; b++) push_byte(2, 8'h40 + 8'(b), b == 39);
    for (int b = 0; b < 16; b++) expect_byte(2, 8'h40 + 8'(b));
    wait_cyc(1);
    check("t3_grant", 32'(bus.grant), 32'b0100);
    wait_cyc(4);
    push_byte(0, 8'hE0, 1'b0);
    push_byte(0, 8'hE1, 1'b1);
    expect_byte(0, 8'hE0);
    expect_byte(0, 8'hE1);
    for (int b = 16; b < 40; b++) expect_byte(2, 8'h40 + 8'(b));
    wait_done("t3", 1500);
    check("t3_releases", 32'(rel_cnt), 32'd4);

    // 4: uart_tx stalled while the owner waits in HOLD
    force_busy = 1'b1;
    push_byte(0, 8'h3C, 1'b1);
    expect_byte(0, 8'h3C);
    s0 = starts;
    wait_cyc(1);
    check("t4_grant", 32'(bus.grant), 32'b0001);
    check("t4_ready_stalled", 32'(bus.req_ready), 32'h0);
    wait_cyc(4);
    check("t4_ready_still_stalled", 32'(bus.req_ready), 32'h0);
    check("t4_no_start", 32'(starts - s0), 32'd0);
    force_busy = 1'b0;
    wait_cyc(1);
    check("t4_tx_start", 32'(bus.tx_start), 32'd1);
    check("t4_tx_data",  32'(bus.tx_data),  32'h3C);
    wait_done("t4", 50);

    // 5: reset during SEND of a 3-byte packet
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b0);
    push_byte(1, 8'h33, 1'b1);
    expect_byte(1, 8'h11);
    n = 0;
    while (!bus.tx_start && n < 20) begin
      wait_cyc(1);
      n++;
    end
    check("t5_first_start_seen", 32'(n < 20), 32'd1);
    wait_cyc(1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_grant",    32'(bus.grant),     32'h0);
    check("t5_rst_active",   32'(bus.active),    32'd0);
    check("t5_rst_tx_start", 32'(bus.tx_start),  32'd0);
    check("t5_rst_tx_data",  32'(bus.tx_data),   32'h00);
    check("t5_rst_grant_id", 32'(bus.grant_id),  32'd3);
    check("t5_rst_ready",    32'(bus.req_ready), 32'h0);
    rq[1].delete();
    wait_cyc(2);
    rst = 1'b0;
    push_byte(0, 8'h77, 1'b1);
    expect_byte(0, 8'h77);
    wait_cyc(1);
    check("t5_regrant", 32'(bus.grant), 32'b0001);
    wait_done("t5", 50);

    // 6: spurious tx_done in HOLD, then in IDLE
    force_busy = 1'b1;
    push_byte(3, 8'h5A, 1'b1);
    expect_byte(3, 8'h5A);
    wait_cyc(1);
    check("t6_grant", 32'(bus.grant), 32'b1000);
    s0 = starts;
    spur_done = 1'b1;
    wait_cyc(1);
    spur_done = 1'b0;
    wait_cyc(2);
    check("t6_hold_active", 32'(bus.active), 32'd1);
    check("t6_hold_grant",  32'(bus.grant),  32'b1000);
    check("t6_hold_no_start", 32'(starts - s0), 32'd0);
    force_busy = 1'b0;
    wait_done("t6", 50);
    spur_done = 1'b1;
    wait_cyc(1);
    spur_done = 1'b0;
    wait_cyc(2);
    check("t6_idle_active", 32'(bus.active), 32'd0);
    check("t6_idle_starts", 32'(starts - s0), 32'd1);

    check("final_expect_drained", 32'(exp_q.size()), 32'd0);
    check("final_ready_legal",    32'(ready_bad),    32'd0);
    check("final_tx_data_stable", 32'(data_glitch),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NREQ independent byte-stream requesters, such as a loopback FIFO, a status reporter and a debug console.
- Grants the transmitter to one requester per packet, using round-robin order.
- Feeds bytes one at a time through the uart_tx tx_start/tx_busy/tx_done handshake.
- Forces rotation after MAX_BURST bytes so that no requester can starve the others.

Parameters:
- NREQ, 4: number of requesters. Must be ≥2.
- MAX_BURST, 16: maximum bytes sent per grant before the grant is forcibly released. Must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  requester i has a byte pending
- req_data  in  NREQ*8  flattened bytes; requester i uses [8i+7:8i]
- req_last  in  NREQ  the pending byte of requester i ends its packet
- req_ready  out  NREQ  byte accepted on a cycle where req_valid[i] & req_ready[i]
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_data  out  8  byte to uart_tx, stable from tx_start until tx_done
- tx_busy  in  1  uart_tx busy
- tx_done  in  1  uart_tx one-cycle frame-complete pulse
- grant  out  NREQ  one-hot current owner; all-zero when no owner
- grant_id  out  $clog2(NREQ)  index of the current or last owner
- active  out  1  a grant is held

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is asynchronous and active-high.
  - On reset: state=IDLE, grant=0, grant_id=NREQ-1, active=0, tx_start=0, tx_data=8'h00, burst_cnt=0, last_flag=0.
  - Reset mid-packet drops the packet with no completion. The same rst also resets uart_tx.
- States: IDLE, HOLD, SEND.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching from (grant_id+1) mod NREQ upward with wrap.
  - At the next edge: grant ← one-hot(pick), grant_id ← pick, active ← 1, burst_cnt ← 0, go to HOLD.
  - Arbitration latency is one cycle. req_ready=0 in IDLE.
- HOLD:
  - req_ready = grant & {NREQ{~tx_busy}}, combinational. All other bits are 0.
  - On accept (req_valid[grant_id] & ready), at the next edge: tx_data ← the owner's byte, tx_start ← 1 for exactly one cycle, last_flag ← req_last[grant_id], burst_cnt ← burst_cnt+1, go to SEND.
  - While the owner holds valid low, the grant is held indefinitely. Valid bits of non-owners are ignored.
- SEND:
  - req_ready=0. Wait for tx_done; tx_busy may rise one cycle after tx_start.
  - On tx_done: if last_flag or burst_cnt==MAX_BURST, go to IDLE with grant ← 0 and active ← 0. grant_id is retained as the rotation pointer.
  - Otherwise go back to HOLD.
  - A tx_done seen in IDLE or HOLD is ignored.
- Throughput: at most one byte in flight. tx_data changes only on accept.
- burst_cnt width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- A forced release mid-packet is legal. The same requester re-competes in IDLE and ranks lowest in priority the next round.
- A single requester that is continuously valid is re-granted after one IDLE cycle.
- The requester order is strictly round-robin. Lowest index wins only when searching from the pointer.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, HOLD, SEND} arb_state_t
  - localparam BYTE_W = 8
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: found, idx.
  - Parameterised by NREQ and reused by future arbiters.

Test Plan:
1. After reset, req0 sends one byte 8'hA5 with last=1.
   - grant=4'b0001 one cycle after valid.
   - tx_start pulses one cycle after accept with tx_data=8'hA5.
   - After tx_done: grant=0, active=0.
2. req1 and req3 are both valid, each with a 3-byte packet, grant_id=0.
   - req1 sends all 3 bytes, then req3 sends its 3 bytes.
   - No interleaving; req_ready is never high for a non-owner.
3. MAX_BURST=16; req2 streams 40 bytes with last only on byte 40.
   - Released after bytes 16 and 32.
   - With req0 also valid, req0's packet is transmitted between bursts.
4. tx_busy is held high in HOLD (uart_tx stalled).
   - req_ready stays 0 and no tx_start is issued.
   - Dropping tx_busy lets the byte be accepted that cycle.
5. rst is asserted during SEND of a 3-byte packet.
   - All outputs return to reset values asynchronously.
   - The next request from req0 is granted normally.
6. tx_done is pulsed spuriously in HOLD.
   - No state change and no extra tx_start.
